// File: rtl/calc_pkg.sv
// Shared types for the 4-bit calculator datapath: opcodes, entry-sequencer states, default width.
package calc_pkg;

  localparam int CALC_WIDTH = 4;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_OR  = 2'd2,
    OP_NEQ = 2'd3
  } calc_op_t;

  typedef enum logic [1:0] {
    S_A     = 2'd0,
    S_B     = 2'd1,
    S_OP    = 2'd2,
    S_ISSUE = 2'd3
  } calc_seq_state_t;

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop synchroniser, stable-level debounce counter and a one-cycle press pulse.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          level_q, level_d;
  logic          level_dly_q, level_dly_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d     = btn_raw;
    sync2_d     = sync1_q;
    level_dly_d = level_q;
    level_d     = level_q;
    cnt_d       = '0;
    // The counter measures how long the synchronised level has disagreed with the accepted one.
    if (sync2_q != level_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      level_q     <= level_d;
      level_dly_q <= level_dly_d;
      cnt_q       <= cnt_d;
    end
  end

  assign press = level_q & ~level_dly_q;

endmodule

// File: rtl/calc_operand_sequencer.sv
// Entry stage: collects A, B and opcode with one ENTER button and issues them as a valid/ready transaction.
module calc_operand_sequencer
  import calc_pkg::*;
#(
  parameter int WIDTH           = CALC_WIDTH,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw,
  input  logic [1:0]       op_sel,
  input  logic             enter_btn,
  input  logic             abort_btn,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  output logic [1:0]       op_out,
  output logic [1:0]       phase,
  output logic [CNT_W-1:0] txn_count
);

  logic enter_press;
  logic abort_press;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter_db (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_raw (enter_btn),
    .press   (enter_press)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_abort_db (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_raw (abort_btn),
    .press   (abort_press)
  );

  calc_seq_state_t  state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  calc_op_t         op_q, op_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    valid_d = valid_q;
    count_d = count_q;

    // A handshake completing on the abort edge is still counted before the clear.
    if (valid_q && out_ready) begin
      count_d = count_q + CNT_W'(1);
      valid_d = 1'b0;
      state_d = S_A;
    end

    if (abort_press) begin
      state_d = S_A;
      a_d     = '0;
      b_d     = '0;
      op_d    = OP_ADD;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        S_A: begin
          if (enter_press) begin
            a_d     = sw;
            state_d = S_B;
          end
        end
        S_B: begin
          if (enter_press) begin
            b_d     = sw;
            state_d = S_OP;
          end
        end
        S_OP: begin
          if (enter_press) begin
            op_d    = calc_op_t'(op_sel);
            valid_d = 1'b1;
            state_d = S_ISSUE;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_A;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= OP_ADD;
      valid_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  assign out_valid = valid_q;
  assign a_out     = a_q;
  assign b_out     = b_q;
  assign op_out    = op_q;
  assign phase     = state_q;
  assign txn_count = count_q;

endmodule

// File: tb/tb_calc_operand_sequencer.sv
// Directed bench for calc_operand_sequencer with a per-cycle reference model and literal spot checks.
module tb_calc_operand_sequencer;

  localparam int DC = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] sw = '0;
  logic [1:0] op_sel = '0;
  logic       enter_btn = 1'b0;
  logic       abort_btn = 1'b0;
  logic       out_ready = 1'b0;
  logic       out_valid;
  logic [3:0] a_out;
  logic [3:0] b_out;
  logic [1:0] op_out;
  logic [1:0] phase;
  logic [7:0] txn_count;

  calc_operand_sequencer #(
    .WIDTH           (4),
    .DEBOUNCE_CYCLES (DC),
    .CNT_W           (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sw        (sw),
    .op_sel    (op_sel),
    .enter_btn (enter_btn),
    .abort_btn (abort_btn),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .a_out     (a_out),
    .b_out     (b_out),
    .op_out    (op_out),
    .phase     (phase),
    .txn_count (txn_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a button level is accepted once the synchronised samples of the
  // last DC cycles all disagree with the currently accepted level.
  logic [DC:0] m_hist [2];
  logic        m_acc [2];
  logic        m_acc_prev [2];
  int          m_phase;
  logic [3:0]  m_a;
  logic [3:0]  m_b;
  logic [1:0]  m_op;
  logic        m_valid;
  int          m_count;

  always @(posedge clk or negedge rst_n) begin : model_blk
    logic       e_pr, a_pr, xfer, raw;
    int         ph, nc;
    logic [3:0] na, nb;
    logic [1:0] no;
    logic       nv;
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_hist[i]     <= '0;
        m_acc[i]      <= 1'b0;
        m_acc_prev[i] <= 1'b0;
      end
      m_phase <= 0;
      m_a     <= '0;
      m_b     <= '0;
      m_op    <= '0;
      m_valid <= 1'b0;
      m_count <= 0;
    end else begin
      e_pr = m_acc[0] && !m_acc_prev[0];
      a_pr = m_acc[1] && !m_acc_prev[1];
      xfer = m_valid && out_ready;
      ph = m_phase; na = m_a; nb = m_b; no = m_op; nv = m_valid; nc = m_count;
      if (xfer) begin
        nc = nc + 1;
        nv = 1'b0;
        ph = 0;
      end
      if (a_pr) begin
        ph = 0; na = '0; nb = '0; no = '0; nv = 1'b0;
      end else if (e_pr && !xfer) begin
        if (ph == 0) begin
          na = sw; ph = 1;
        end else if (ph == 1) begin
          nb = sw; ph = 2;
        end else if (ph == 2) begin
          no = op_sel; ph = 3; nv = 1'b1;
        end
      end
      m_phase <= ph;
      m_a     <= na;
      m_b     <= nb;
      m_op    <= no;
      m_valid <= nv;
      m_count <= nc;
      for (int i = 0; i < 2; i++) begin
        raw = (i == 0) ? enter_btn : abort_btn;
        m_hist[i]     <= {m_hist[i][DC-1:0], raw};
        m_acc_prev[i] <= m_acc[i];
        if (m_hist[i][DC:1] == {DC{~m_acc[i]}}) m_acc[i] <= ~m_acc[i];
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("valid", 32'(out_valid), 32'(m_valid));
      chk("a_out", 32'(a_out), 32'(m_a));
      chk("b_out", 32'(b_out), 32'(m_b));
      chk("op_out", 32'(op_out), 32'(m_op));
      chk("phase", 32'(phase), 32'(m_phase));
      chk("txn_count", 32'(txn_count), 32'(m_count % 256));
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press_enter();
    enter_btn = 1'b1;
    step(6);
    enter_btn = 1'b0;
    step(8);
  endtask

  task automatic press_abort();
    abort_btn = 1'b1;
    step(6);
    abort_btn = 1'b0;
    step(8);
  endtask

  initial begin
    // Reset held with random inputs
    for (int i = 0; i < 4; i++) begin
      sw = 4'($urandom); op_sel = 2'($urandom);
      enter_btn = 1'($urandom); abort_btn = 1'($urandom); out_ready = 1'($urandom);
      step(1);
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_phase", 32'(phase), 32'd0);
      chk("rst_abop", 32'({a_out, b_out, op_out}), 32'd0);
      chk("rst_count", 32'(txn_count), 32'd0);
    end
    sw = '0; op_sel = '0; enter_btn = 1'b0; abort_btn = 1'b0; out_ready = 1'b0;
    step(1);
    rst_n = 1'b1;
    step(2);

    // Bouncing contact then a short glitch: nothing captured
    for (int i = 0; i < 10; i++) begin
      enter_btn = ~enter_btn;
      step(2);
    end
    enter_btn = 1'b0;
    step(8);
    chk("bounce_phase", 32'(phase), 32'd0);
    sw = 4'd7;
    enter_btn = 1'b1;
    step(3);
    enter_btn = 1'b0;
    step(8);
    chk("glitch_phase", 32'(phase), 32'd0);
    sw = 4'd9;
    press_enter();
    chk("clean_phase", 32'(phase), 32'd1);
    chk("clean_a", 32'(a_out), 32'd9);

    // Asynchronous reset in mid-cycle
    #2 rst_n = 1'b0;
    #1;
    chk("async_phase", 32'(phase), 32'd0);
    chk("async_a", 32'(a_out), 32'd0);
    step(2);
    rst_n = 1'b1;
    step(2);

    // Full transaction with downstream ready
    out_ready = 1'b1;
    sw = 4'd5; press_enter();
    sw = 4'd3; press_enter();
    op_sel = 2'd1; press_enter();
    chk("full_count", 32'(txn_count), 32'd1);
    chk("full_phase", 32'(phase), 32'd0);
    chk("full_valid", 32'(out_valid), 32'd0);
    chk("full_a", 32'(a_out), 32'd5);
    chk("full_b", 32'(b_out), 32'd3);
    chk("full_op", 32'(op_out), 32'd1);

    // Backpressure with an extra ENTER while waiting
    out_ready = 1'b0;
    sw = 4'd12; press_enter();
    sw = 4'd7; press_enter();
    op_sel = 2'd3; press_enter();
    step(10);
    sw = 4'd1; press_enter();
    chk("bp_phase", 32'(phase), 32'd3);
    chk("bp_valid", 32'(out_valid), 32'd1);
    chk("bp_a", 32'(a_out), 32'd12);
    chk("bp_b", 32'(b_out), 32'd7);
    chk("bp_op", 32'(op_out), 32'd3);
    out_ready = 1'b1;
    step(1);
    out_ready = 1'b0;
    step(2);
    chk("bp_count", 32'(txn_count), 32'd2);
    chk("bp_done_valid", 32'(out_valid), 32'd0);
    chk("bp_done_phase", 32'(phase), 32'd0);

    // Abort in S_OP, then abort and enter together in S_A
    sw = 4'd2; press_enter();
    sw = 4'd4; press_enter();
    chk("ab_pre_phase", 32'(phase), 32'd2);
    press_abort();
    chk("ab_phase", 32'(phase), 32'd0);
    chk("ab_a", 32'(a_out), 32'd0);
    chk("ab_b", 32'(b_out), 32'd0);
    sw = 4'd6;
    enter_btn = 1'b1; abort_btn = 1'b1;
    step(6);
    enter_btn = 1'b0; abort_btn = 1'b0;
    step(8);
    chk("ab_en_phase", 32'(phase), 32'd0);
    chk("ab_en_a", 32'(a_out), 32'd0);

    // Counter wrap
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(1);
    out_ready = 1'b1;
    for (int t = 0; t < 256; t++) begin
      sw = 4'(t); press_enter();
      sw = 4'(t + 3); press_enter();
      op_sel = 2'(t); press_enter();
    end
    chk("wrap_256", 32'(txn_count), 32'd0);
    sw = 4'd8; press_enter();
    sw = 4'd2; press_enter();
    op_sel = 2'd2; press_enter();
    chk("wrap_257", 32'(txn_count), 32'd1);
    chk("wrap_op", 32'(op_out), 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
